rv_dmem: RTL
============

# rv_dmem

Data-memory and MMIO slave for the multicycle RISC-V core. It connects directly to the core's data port: `dmem_addr`, `dmem_dataout` and `memrw` come in, and `dmem_datain` goes back. Internally it holds a word-organised RAM and a small MMIO window. The window contains a byte transmit FIFO with a valid/ready output, a status register and an optional free-running cycle counter. Reads are combinational, matching the core's single-cycle memory-access state. Writes commit on the clock edge.

## Interface
- `DPWIDTH`, 32: datapath and word width.
- `DEPTH`, 1024: RAM depth in words; power of two.
- `TXDEPTH`, 4: transmit FIFO depth in bytes; power of two, 2..128.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `dmem_addr` input `DPWIDTH`: byte address from the core.
- `dmem_dataout` input `DPWIDTH`: write data from the core.
- `memrw` input 1: 1 = write this cycle, 0 = read.
- `dmem_datain` output `DPWIDTH`: read data to the core; combinational.
- `tx_data` output 8: FIFO head byte.
- `tx_valid` output 1: FIFO non-empty.
- `tx_ready` input 1: consumer accepts `tx_data` this cycle.

## Operation
- **Address decode.** MMIO is selected when `dmem_addr[31:4] == 28'hFFFFFFF`. Any other address selects RAM.
  - RAM index = `dmem_addr[log2(DEPTH)+1:2]`.
  - Address bits [1:0] are ignored, and higher bits alias, so the RAM wraps modulo DEPTH.
- **RAM.**
  - Write: the full word is written when `memrw=1`.
  - Read: `dmem_datain` = word at the index.
  - Contents are not reset.
- **MMIO registers** (selected by `dmem_addr[3:2]`):
  - `0xF0` TXDATA.
    - Write pushes `dmem_dataout[7:0]` into the FIFO.
    - Read returns 0.
  - `0xF4` STATUS.
    - Read: bits [7:0] = FIFO count, bit 8 = full, bit 9 = overflow (sticky), other bits 0.
    - Any write clears overflow.
  - `0xF8` CYCLE: read returns the counter value (see Configuration). Writes are ignored.
  - `0xFC`: reads 0; writes ignored.
- MMIO writes never modify RAM.
- **FIFO.**
  - Circular buffer with read and write pointers plus a count of width `log2(TXDEPTH)+1`.
  - Pop when `tx_valid && tx_ready`.
  - Push when a TXDATA write occurs and either the FIFO is not full or a pop happens in the same cycle.
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
  - Push while full with no pop: the byte is dropped, overflow is set and the pointers are unchanged.
  - Pointers wrap modulo TXDEPTH.
  - `tx_data` = the head entry while `tx_valid`, and 0 when empty.
  - `tx_data` must be held stable while `tx_valid && !tx_ready`.
- **Reset.**
  - Outputs: `tx_valid=0`, `tx_data=0`.
  - FIFO state: count=0, pointers=0, overflow=0.
  - Cycle counter: 0.
  - `dmem_datain` follows the address combinationally at all times, including during reset.
  - Writes during a `rst` cycle are ignored; reset takes priority over push, pop and RAM write.

## Timing
- Read latency is 0 cycles: `dmem_datain` is valid in the same cycle the address is stable.
- A write is visible to reads from the cycle after the edge on which `memrw=1` was sampled.
- The core never issues read and write in one cycle; a read in the same cycle as a write returns the old value.
- STATUS and count reads reflect state before the current edge.
  - A TXDATA write followed by a STATUS read in the next cycle shows count+1.
- `tx_valid` rises one cycle after the first push into an empty FIFO.
  - The FIFO has no fall-through: an empty FIFO with a push in the same cycle does not present the byte until the next cycle.
- After a pop of the last entry, `tx_valid` falls at the next edge.

## Configuration
- `RV_DMEM_CYCCNT_EN` defined:
  - A 32-bit counter increments every cycle while `rst=0` and wraps from `0xFFFFFFFF` to 0.
  - A CYCLE read returns its pre-edge value; the first cycle after reset reads 0.
- `RV_DMEM_CYCCNT_EN` undefined:
  - The counter flops are not present.
  - A CYCLE read returns 0.

## Test plan
- **RAM write/read.** Write `0xDEADBEEF` to `0x00000010`, then read `0x00000010` and `0x00000013` -> both return `0xDEADBEEF`. Read `0x00001010` with DEPTH=1024 -> `0xDEADBEEF` (alias).
- **FIFO fill and drain.** With `tx_ready=0`, write `0x41`, `0x42`, `0x43`, `0x44` to `0xFFFFFFF0` -> STATUS = `0x104`, `tx_data=0x41`. Raise `tx_ready` -> bytes `0x41`..`0x44` emerge on consecutive cycles, then `tx_valid=0` and STATUS = 0.
- **Overflow.**
  - With `tx_ready=0` and the FIFO full, write `0x55` -> STATUS bit 9 = 1, count stays 4, the dropped byte never appears.
  - Write STATUS -> bit 9 = 0.
- **Simultaneous push/pop when full.** With the FIFO full and `tx_ready=1`, write `0x66` -> count stays 4, no overflow, and `0x66` is emitted 4th after the in-flight byte.
- **Cycle counter** (`RV_DMEM_CYCCNT_EN` defined). Deassert `rst`, then read CYCLE 10 cycles later -> 10. Force the counter to `0xFFFFFFFF` -> next read returns 0. Without the macro, any read returns 0.
- **Reset mid-operation.** Assert `rst` with 3 bytes queued and `tx_ready=1` -> next cycle `tx_valid=0`, STATUS = 0, no byte popped on the reset edge, RAM contents retained.

Source files
------------

// File: rtl/rv_dmem_if.sv
// rv_dmem_if: data-port bundle between the multicycle RISC-V core and rv_dmem,
// plus the byte-stream transmit handshake leaving the MMIO window.
// master = core/consumer side, slave = rv_dmem.
interface rv_dmem_if #(
    parameter int DPWIDTH = 32
);
    logic [DPWIDTH-1:0] dmem_addr;
    logic [DPWIDTH-1:0] dmem_dataout;
    logic               memrw;
    logic [DPWIDTH-1:0] dmem_datain;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;

    modport master (
        output dmem_addr,
        output dmem_dataout,
        output memrw,
        output tx_ready,
        input  dmem_datain,
        input  tx_data,
        input  tx_valid
    );

    modport slave (
        input  dmem_addr,
        input  dmem_dataout,
        input  memrw,
        input  tx_ready,
        output dmem_datain,
        output tx_data,
        output tx_valid
    );
endinterface

// File: rtl/rv_dmem.sv
// rv_dmem: word-organised data RAM plus a small MMIO window at 0xFFFFFFF0..FC
// (TX byte FIFO, STATUS, CYCLE). Reads are combinational, writes commit on clk.
// Optional free-running cycle counter: define RV_DMEM_CYCCNT_EN to build it;
// without it CYCLE reads as zero and no counter flops exist.
module rv_dmem #(
    parameter int DPWIDTH = 32,
    parameter int DEPTH   = 1024,
    parameter int TXDEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    rv_dmem_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(TXDEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(TXDEPTH);

    // storage and state
    logic [DPWIDTH-1:0] r_ram  [DEPTH];
    logic [7:0]         r_fifo [TXDEPTH];
    logic [PW-1:0]      r_rptr;
    logic [PW-1:0]      r_wptr;
    logic [CW-1:0]      r_count;
    logic               r_ovf;
    logic               r_tx_valid;
    logic [7:0]         r_tx_data;

    // decode and next-state wires
    logic               w_mmio_sel;
    logic [AW-1:0]      w_ram_idx;
    logic [1:0]         w_reg_sel;
    logic               w_ram_wr;
    logic               w_txdata_wr;
    logic               w_status_wr;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [PW-1:0]      w_rptr_nxt;
    logic [PW-1:0]      w_wptr_nxt;
    logic [CW-1:0]      w_count_nxt;
    logic [7:0]         w_head_nxt;
    logic [DPWIDTH-1:0] w_status;
    logic [DPWIDTH-1:0] w_cycle;
    logic [DPWIDTH-1:0] w_rdata;
    logic               w_unused_addr;

    assign w_mmio_sel  = (bus.dmem_addr[31:4] == 28'hFFFFFFF);
    assign w_ram_idx   = bus.dmem_addr[AW+1:2];
    assign w_reg_sel   = bus.dmem_addr[3:2];
    assign w_ram_wr    = bus.memrw & ~w_mmio_sel;
    assign w_txdata_wr = bus.memrw & w_mmio_sel & (w_reg_sel == 2'd0);
    assign w_status_wr = bus.memrw & w_mmio_sel & (w_reg_sel == 2'd1);

    // Byte lane bits never matter: every access is a full word.
    assign w_unused_addr = &{1'b0, bus.dmem_addr[1:0]};

    // r_tx_valid mirrors (r_count != 0), so it doubles as the non-empty flag.
    assign w_full = (r_count == CNT_FULL);
    assign w_pop  = r_tx_valid & bus.tx_ready;
    assign w_push = w_txdata_wr & (~w_full | w_pop);
    assign w_drop = w_txdata_wr & w_full & ~w_pop;

    // FIFO pointer/count next state; pointers wrap naturally at TXDEPTH.
    always_comb begin
        w_rptr_nxt  = r_rptr;
        w_wptr_nxt  = r_wptr;
        w_count_nxt = r_count;
        if (w_pop) begin
            w_rptr_nxt = r_rptr + PTR_ONE;
        end else begin
            w_rptr_nxt = r_rptr;
        end
        if (w_push) begin
            w_wptr_nxt = r_wptr + PTR_ONE;
        end else begin
            w_wptr_nxt = r_wptr;
        end
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Head byte after this edge; the slot being pushed has not landed yet, so bypass it.
    always_comb begin
        w_head_nxt = 8'h00;
        if (w_count_nxt == '0) begin
            w_head_nxt = 8'h00;
        end else if (w_push && (w_rptr_nxt == r_wptr)) begin
            w_head_nxt = bus.dmem_dataout[7:0];
        end else begin
            w_head_nxt = r_fifo[w_rptr_nxt];
        end
    end

    // FIFO control state, sticky overflow and registered TX outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_rptr     <= w_rptr_nxt;
            r_wptr     <= w_wptr_nxt;
            r_count    <= w_count_nxt;
            r_tx_valid <= (w_count_nxt != '0);
            r_tx_data  <= w_head_nxt;
            if (w_status_wr) begin
                r_ovf <= 1'b0;
            end else if (w_drop) begin
                r_ovf <= 1'b1;
            end else begin
                r_ovf <= r_ovf;
            end
        end
    end

    // FIFO byte storage; not reset, only the pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_fifo[r_wptr] <= bus.dmem_dataout[7:0];
        end
    end

    // Data RAM write port; contents survive reset, reset cycles block writes.
    always_ff @(posedge clk) begin
        if (!rst && w_ram_wr) begin
            r_ram[w_ram_idx] <= bus.dmem_dataout;
        end
    end

`ifdef RV_DMEM_CYCCNT_EN
    logic [31:0] r_cycle;

    // Free-running cycle counter, wraps at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle <= 32'h0000_0000;
        end else begin
            r_cycle <= r_cycle + 32'h0000_0001;
        end
    end

    assign w_cycle = DPWIDTH'(r_cycle);
`else
    assign w_cycle = '0;
`endif

    // STATUS word assembled from pre-edge state.
    always_comb begin
        w_status      = '0;
        w_status[7:0] = 8'(r_count);
        w_status[8]   = w_full;
        w_status[9]   = r_ovf;
    end

    // Combinational read mux: MMIO window or RAM word.
    always_comb begin
        w_rdata = '0;
        if (w_mmio_sel) begin
            case (w_reg_sel)
                2'd0:    w_rdata = '0;
                2'd1:    w_rdata = w_status;
                2'd2:    w_rdata = w_cycle;
                default: w_rdata = '0;
            endcase
        end else begin
            w_rdata = r_ram[w_ram_idx];
        end
    end

    assign bus.dmem_datain = w_rdata;
    assign bus.tx_valid    = r_tx_valid;
    assign bus.tx_data     = r_tx_data;
endmodule
